instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the multicycle CPU. Holds the program counter and runs a request/acknowledge read against instruction memory. On each completed read it drives the fetched word and a one-cycle write strobe into the instruction register. It is started by the control FSM, accepts branch/jump redirects, and flags memory timeouts.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- PC_STEP, 4, sequential PC increment in bytes
- TIMEOUT, 255, maximum cycles mem_req may wait for mem_ack (1..255)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- fetch_start  in  1  control FSM request to fetch at current PC
- pc_load  in  1  redirect PC to pc_next
- pc_next  in  32  branch/jump target
- mem_req  out  1  instruction memory read request
- mem_addr  out  32  read address, equal to pc while mem_req=1
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  read complete
- ir_d  out  32  fetched word, feeds instruction register d
- ir_enable  out  1  one-cycle write strobe to instruction register
- pc  out  32  current program counter
- pc_plus_step  out  32  pc + PC_STEP (combinational)
- busy  out  1  fetch in flight
- fetch_done  out  1  one-cycle pulse, fetch completed
- fetch_err  out  1  one-cycle pulse, fetch timed out

## Operation
- States: IDLE, WAIT.
- IDLE:
  - fetch_start=1 -> WAIT, mem_req=1 next cycle, timeout counter cleared.
  - pc_load=1 -> pc <= pc_next.
  - fetch_start and pc_load in the same cycle: PC loads pc_next and the fetch uses pc_next as its address.
- WAIT:
  - mem_req=1, busy=1, mem_addr=pc. fetch_start is ignored.
  - mem_ack=1: ir_d <= mem_rdata, ir_enable and fetch_done pulse, state -> IDLE.
    - No redirect pending: pc <= pc + PC_STEP (32-bit wrap, 32'hFFFF_FFFC + 4 = 0).
    - Redirect pending: pc <= pending target, pending flag cleared.
  - pc_load=1 in WAIT: target stored in the pending register. A later pc_load overwrites it. The in-flight fetch still completes at the old address.
  - pc_load and mem_ack in the same cycle: the new pc_next wins, and the pending register is not used.
  - Counter increments each WAIT cycle without ack. When it reaches TIMEOUT (no ack in the TIMEOUT-th cycle):
    - fetch_err pulses, state -> IDLE, mem_req drops.
    - pc, ir_d and ir_enable are unchanged.
    - A pending redirect is applied to pc.
- mem_ack while mem_req=0 is ignored.
- Reset values: pc=RESET_PC, ir_d=0, mem_req=0, ir_enable=0, fetch_done=0, fetch_err=0, busy=0, pending cleared, counter 0, state IDLE.
- Reset asserted mid-fetch aborts immediately: no strobe, and a late mem_ack after release is ignored.

## Timing
- All outputs are registered except pc_plus_step and mem_addr (mem_addr = pc).
- fetch_start sampled in cycle 0 -> mem_req high from cycle 1.
- mem_ack sampled in cycle k (k>=1) -> in cycle k+1: ir_enable=1, fetch_done=1, ir_d and pc hold their new values, mem_req=0.
- Minimum fetch_start-to-ir_enable latency: 2 cycles.
- ir_d is stable from cycle k+1 until the next completed fetch; the instruction register captures it at the end of cycle k+1.
- Back-to-back: fetch_start in the fetch_done cycle is accepted (state is IDLE) -> mem_req again in the following cycle.
- Timeout: with no ack in cycles 1..TIMEOUT, fetch_err=1 in cycle TIMEOUT+1.

## Structure
- The shared package cpu_pkg holds:
  - fetch state encoding (IDLE, WAIT)
  - WORD_W=32
  - default RESET_PC and PC_STEP constants
- One sub-module: pc_register, covering async reset to RESET_PC, load and step, with load priority over step.
- FSM, timeout counter, pending-redirect register and IR data register live in instruction_fetch.

## Test plan
- Reset, then release; fetch_start; mem_ack in cycle 3 with rdata 32'h8C22_0004 -> mem_addr=0 in cycles 1-3; ir_d=32'h8C22_0004, ir_enable=1, fetch_done=1 in cycle 4; pc=4.
- Three back-to-back fetches, each acked one cycle after mem_req -> addresses 0, 4, 8; three single-cycle ir_enable pulses; pc=12.
- pc_load=1, pc_next=32'h100 in WAIT, ack two cycles later -> the fetch completes at the old address; pc=32'h100 after fetch_done; the next fetch requests 32'h100.
- TIMEOUT=4, ack never arrives -> mem_req high for cycles 1-4, fetch_err in cycle 5, no ir_enable, pc and ir_d unchanged.
- pc_load=1 with pc_next=32'hFFFF_FFFC, then fetch, ack -> pc wraps to 0.
- Reset asserted in WAIT, ack arrives after release -> all outputs at reset values, no ir_enable, pc=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, default PC constants and the
// fetch-stage state encoding.
package cpu_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEF_PC_STEP  = 32'd4;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_WAIT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus: request/acknowledge with address and data.
interface instruction_fetch_if;
  import cpu_pkg::*;
  logic              mem_req;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_addr, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_addr, output mem_rdata, mem_ack);
endinterface

// File: rtl/pc_register.sv
// Program counter: async reset to RESET_PC, load has priority over step.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [WORD_W-1:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [WORD_W-1:0] load_val_i,
  output logic [WORD_W-1:0] pc_o,
  output logic [WORD_W-1:0] pc_plus_step_o
);
  logic [WORD_W-1:0] pc_q, pc_d;

  // Plain modular add: the top of the address space wraps to zero.
  assign pc_plus_step_o = pc_q + PC_STEP;
  assign pc_o           = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i)      pc_d = load_val_i;
    else if (step_i) pc_d = pc_plus_step_o;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, request/ack read of instruction memory, IR write strobe,
// deferred branch redirect and request timeout.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [WORD_W-1:0] PC_STEP  = DEF_PC_STEP,
  parameter int unsigned       TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_start,
  input  logic                       pc_load,
  input  logic [WORD_W-1:0]          pc_next,
  instruction_fetch_if.master        mem,
  output logic [WORD_W-1:0]          ir_d,
  output logic                       ir_enable,
  output logic [WORD_W-1:0]          pc,
  output logic [WORD_W-1:0]          pc_plus_step,
  output logic                       busy,
  output logic                       fetch_done,
  output logic                       fetch_err
);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  fetch_state_e      state_q;
  logic [7:0]        cnt_q;
  logic              pend_vld_q;
  logic [WORD_W-1:0] pend_pc_q;
  logic [WORD_W-1:0] ir_q;
  logic              ir_en_q, done_q, err_q, req_q;

  logic              ack, tmo;
  logic              pc_ld, pc_step;
  logic [WORD_W-1:0] pc_ld_val;

  assign ack = (state_q == F_WAIT) && mem.mem_ack;
  assign tmo = (state_q == F_WAIT) && !mem.mem_ack && (cnt_q == TMO_LAST);

  // A redirect arriving on the closing cycle beats an older pending target.
  always_comb begin
    pc_ld     = 1'b0;
    pc_step   = 1'b0;
    pc_ld_val = pc_next;
    if (state_q == F_IDLE) begin
      pc_ld = pc_load;
    end else if (ack || tmo) begin
      if (pc_load) begin
        pc_ld = 1'b1;
      end else if (pend_vld_q) begin
        pc_ld     = 1'b1;
        pc_ld_val = pend_pc_q;
      end else begin
        pc_step = ack;
      end
    end
  end

  pc_register #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk            (clk),
    .reset          (reset),
    .load_i         (pc_ld),
    .step_i         (pc_step),
    .load_val_i     (pc_ld_val),
    .pc_o           (pc),
    .pc_plus_step_o (pc_plus_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= F_IDLE;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
      ir_q       <= '0;
      ir_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      ir_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        F_IDLE: begin
          if (fetch_start) begin
            state_q <= F_WAIT;
            req_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        F_WAIT: begin
          if (ack) begin
            ir_q       <= mem.mem_rdata;
            ir_en_q    <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= F_IDLE;
            req_q      <= 1'b0;
            pend_vld_q <= 1'b0;
          end else if (tmo) begin
            err_q      <= 1'b1;
            state_q    <= F_IDLE;
            req_q      <= 1'b0;
            pend_vld_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (pc_load) begin
              pend_vld_q <= 1'b1;
              pend_pc_q  <= pc_next;
            end
          end
        end
        default: begin
          state_q <= F_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = pc;
  assign ir_d         = ir_q;
  assign ir_enable    = ir_en_q;
  assign busy         = req_q;
  assign fetch_done   = done_q;
  assign fetch_err    = err_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed plus random bench for instruction_fetch against a transaction-level
// model of the fetch stage.
module tb_instruction_fetch;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_next = '0;
  logic [31:0] ir_d, pc, pc_plus_step;
  logic        ir_enable, busy, fetch_done, fetch_err;

  instruction_fetch_if mif ();

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4),
    .TIMEOUT  (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_start  (fetch_start),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .mem          (mif),
    .ir_d         (ir_d),
    .ir_enable    (ir_enable),
    .pc           (pc),
    .pc_plus_step (pc_plus_step),
    .busy         (busy),
    .fetch_done   (fetch_done),
    .fetch_err    (fetch_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: one outstanding fetch, its age in wait cycles, an optional
  // deferred redirect, and the pulses expected in the following cycle.
  logic [31:0] m_pc, m_ir, m_pend;
  bit          m_fly, m_has_pend, m_en, m_done, m_err;
  int          m_age;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 32'h0; m_pend = 32'h0;
    m_fly = 0; m_has_pend = 0; m_en = 0; m_done = 0; m_err = 0; m_age = 0;
  endtask

  task automatic model_step(input bit fs, input bit pl, input logic [31:0] pn,
                            input bit ack, input logic [31:0] rd);
    m_en = 0; m_done = 0; m_err = 0;
    if (!m_fly) begin
      if (pl) m_pc = pn;
      if (fs) begin m_fly = 1; m_age = 0; end
    end else begin
      m_age++;
      if (ack || m_age == TMO) begin
        if (ack) begin m_ir = rd; m_en = 1; m_done = 1; end
        else m_err = 1;
        if (pl)              m_pc = pn;
        else if (m_has_pend) m_pc = m_pend;
        else if (ack)        m_pc = m_pc + 32'd4;
        m_has_pend = 0;
        m_fly      = 0;
      end else if (pl) begin
        m_has_pend = 1;
        m_pend     = pn;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, " mem_req"},      32'(mif.mem_req),  32'(m_fly));
    chk({ctx, " busy"},         32'(busy),         32'(m_fly));
    chk({ctx, " mem_addr"},     mif.mem_addr,      m_pc);
    chk({ctx, " pc"},           pc,                m_pc);
    chk({ctx, " pc_plus_step"}, pc_plus_step,      m_pc + 32'd4);
    chk({ctx, " ir_d"},         ir_d,              m_ir);
    chk({ctx, " ir_enable"},    32'(ir_enable),    32'(m_en));
    chk({ctx, " fetch_done"},   32'(fetch_done),   32'(m_done));
    chk({ctx, " fetch_err"},    32'(fetch_err),    32'(m_err));
  endtask

  // Drive at negedge, let the DUT sample at posedge, check at the next negedge.
  task automatic tick(input string ctx, input bit fs, input bit pl, input logic [31:0] pn,
                      input bit ack, input logic [31:0] rd);
    fetch_start   = fs;
    pc_load       = pl;
    pc_next       = pn;
    mif.mem_ack   = ack;
    mif.mem_rdata = rd;
    @(posedge clk);
    model_step(fs, pl, pn, ack, rd);
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic do_reset(input string ctx);
    fetch_start = 0; pc_load = 0; mif.mem_ack = 0;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    do_reset("reset");

    // Single fetch, ack in cycle 3.
    tick("t1 c1", 1, 0, 0, 0, 0);
    chk("t1 c1 addr", mif.mem_addr, 32'h0);
    tick("t1 c2", 0, 0, 0, 0, 0);
    tick("t1 c3", 0, 0, 0, 0, 0);
    chk("t1 c3 req", 32'(mif.mem_req), 32'd1);
    tick("t1 c4", 0, 0, 0, 1, 32'h8C22_0004);
    chk("t1 ir_d", ir_d, 32'h8C22_0004);
    chk("t1 ir_enable", 32'(ir_enable), 32'd1);
    chk("t1 pc", pc, 32'h4);

    // Three back-to-back fetches from a fresh reset.
    do_reset("t2 reset");
    for (int i = 0; i < 3; i++) begin
      tick("t2 req", 1, 0, 0, 0, 0);
      chk("t2 addr", mif.mem_addr, 32'(4 * i));
      tick("t2 ack", 0, 0, 0, 1, 32'hA000_0000 + 32'(i));
      chk("t2 strobe", 32'(ir_enable), 32'd1);
    end
    tick("t2 idle", 0, 0, 0, 0, 0);
    chk("t2 strobe low", 32'(ir_enable), 32'd0);
    chk("t2 pc", pc, 32'd12);

    // Redirect while waiting: completes at old address, then jumps.
    tick("t3 req", 1, 0, 0, 0, 0);
    tick("t3 load", 0, 1, 32'h100, 0, 0);
    chk("t3 addr held", mif.mem_addr, 32'd12);
    tick("t3 wait", 0, 0, 0, 0, 0);
    tick("t3 ack", 0, 0, 0, 1, 32'h1234_5678);
    chk("t3 pc", pc, 32'h100);
    tick("t3 req2", 1, 0, 0, 0, 0);
    chk("t3 addr2", mif.mem_addr, 32'h100);
    tick("t3 ack2", 0, 0, 0, 1, 32'h0BAD_F00D);

    // Timeout: no ack in cycles 1..TMO, error in TMO+1.
    tick("t4 req", 1, 0, 0, 0, 0);
    for (int i = 2; i <= TMO; i++) tick("t4 wait", 0, 0, 0, 0, 0);
    chk("t4 req still", 32'(mif.mem_req), 32'd1);
    tick("t4 err", 0, 0, 0, 0, 0);
    chk("t4 fetch_err", 32'(fetch_err), 32'd1);
    chk("t4 no strobe", 32'(ir_enable), 32'd0);
    chk("t4 pc", pc, 32'h104);
    chk("t4 ir_d", ir_d, 32'h0BAD_F00D);

    // PC wrap at top of address space.
    tick("t5 load", 0, 1, 32'hFFFF_FFFC, 0, 0);
    tick("t5 req", 1, 0, 0, 0, 0);
    chk("t5 addr", mif.mem_addr, 32'hFFFF_FFFC);
    tick("t5 ack", 0, 0, 0, 1, 32'h0000_0013);
    chk("t5 pc wrap", pc, 32'h0);

    // Reset mid-fetch, late ack after release.
    tick("t6 load", 0, 1, 32'h40, 0, 0);
    tick("t6 req", 1, 0, 0, 0, 0);
    tick("t6 wait", 0, 0, 0, 0, 0);
    #2;
    do_reset("t6 async reset");
    tick("t6 late ack", 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t6 no strobe", 32'(ir_enable), 32'd0);
    chk("t6 pc", pc, 32'h0);

    // Random traffic, including acks while idle and redirects mid-fetch.
    for (int i = 0; i < 400; i++) begin
      tick("rnd",
           bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 7) == 0),
           $urandom & 32'hFFFF_FFFC,
           bit'($urandom_range(0, 2) == 0),
           $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
